// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Snoops a time-multiplexed 7-segment display bus and rebuilds the shown
// hex word. Each strobed digit must hold a stable strobe + pattern for
// SETTLE cycles before it is captured into a per-digit shadow register.
// Once every digit has been captured, the shadows are published in one
// cycle together with a frame_valid pulse.
//
// Ports:
//   clk          system clock
//   clr          synchronous active-high reset
//   an           anode strobes, active-low, one-hot-low for a driven digit
//   a_to_g       segment lines, [6]=a .. [0]=g, lit when 0
//   value        captured word, digit i at value[4i+3:4i]
//   frame_valid  one-cycle pulse when value/err_mask update
//   err_mask     bit i set = digit i showed a non-hex pattern last frame
//   stale        no capture for TIMEOUT cycles
//
// Optional feature (macro SEG7_DP_CAPTURE_EN): adds dp input (active-low
// decimal point, part of the stability check) and dp_mask output
// (bit i = decimal point lit in the last frame).
module seg7_scan_capture #(
    parameter int DIGITS  = 4,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            a_to_g,
`ifdef SEG7_DP_CAPTURE_EN
    input  logic                  dp,
    output logic [DIGITS-1:0]     dp_mask,
`endif
    output logic [4*DIGITS-1:0]   value,
    output logic                  frame_valid,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  stale
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETTLING, HOLD} state_t;

    // Two-flop synchronizers on the display bus
    logic [DIGITS-1:0] an_s1_reg, an_s2_reg;
    logic [6:0]        seg_s1_reg, seg_s2_reg;
`ifdef SEG7_DP_CAPTURE_EN
    logic              dp_s1_reg, dp_s2_reg, ref_dp_reg, ref_dp_next;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            an_s1_reg  <= '0;
            an_s2_reg  <= '0;
            seg_s1_reg <= '0;
            seg_s2_reg <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            dp_s1_reg  <= 1'b0;
            dp_s2_reg  <= 1'b0;
`endif
        end else begin
            an_s1_reg  <= an;
            an_s2_reg  <= an_s1_reg;
            seg_s1_reg <= a_to_g;
            seg_s2_reg <= seg_s1_reg;
`ifdef SEG7_DP_CAPTURE_EN
            dp_s1_reg  <= dp;
            dp_s2_reg  <= dp_s1_reg;
`endif
        end
    end

    // Strobe is usable only when exactly one anode is pulled low
    logic [3:0]       zero_cnt;
    logic [IDX_W-1:0] strobe_idx;
    logic             strobe_ok;

    always_comb begin
        zero_cnt   = '0;
        strobe_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s2_reg[i]) begin
                zero_cnt   = zero_cnt + 4'd1;
                strobe_idx = IDX_W'(i);
            end
        end
        strobe_ok = (zero_cnt == 4'd1);
    end

    // Segment pattern to nibble; unknown patterns give 0 plus an error flag
    logic [3:0] dec_nib;
    logic       dec_err;

    always_comb begin
        dec_err = 1'b0;
        case (seg_s2_reg)
            7'h01: dec_nib = 4'h0;
            7'h4F: dec_nib = 4'h1;
            7'h12: dec_nib = 4'h2;
            7'h06: dec_nib = 4'h3;
            7'h4C: dec_nib = 4'h4;
            7'h24: dec_nib = 4'h5;
            7'h20: dec_nib = 4'h6;
            7'h0F: dec_nib = 4'h7;
            7'h00: dec_nib = 4'h8;
            7'h04: dec_nib = 4'h9;
            7'h08: dec_nib = 4'hA;
            7'h60: dec_nib = 4'hB;
            7'h31: dec_nib = 4'hC;
            7'h42: dec_nib = 4'hD;
            7'h30: dec_nib = 4'hE;
            7'h38: dec_nib = 4'hF;
            default: begin
                dec_nib = 4'h0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Dwell tracking FSM
    state_t           state_reg, state_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0] ref_idx_reg, ref_idx_next;
    logic [6:0]       ref_seg_reg, ref_seg_next;
    logic             same, capture;

    always_comb begin
        same = (strobe_idx == ref_idx_reg) && (seg_s2_reg == ref_seg_reg);
`ifdef SEG7_DP_CAPTURE_EN
        same = same && (dp_s2_reg == ref_dp_reg);
`endif
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ref_idx_next = ref_idx_reg;
        ref_seg_next = ref_seg_reg;
`ifdef SEG7_DP_CAPTURE_EN
        ref_dp_next  = ref_dp_reg;
`endif
        capture      = 1'b0;
        // A changed (but valid) strobe/pattern always restarts the dwell
        if (strobe_ok && (state_reg == IDLE || !same)) begin
            state_next   = SETTLING;
            cnt_next     = 8'd1;
            ref_idx_next = strobe_idx;
            ref_seg_next = seg_s2_reg;
`ifdef SEG7_DP_CAPTURE_EN
            ref_dp_next  = dp_s2_reg;
`endif
        end else if (!strobe_ok) begin
            state_next = IDLE;
        end else if (state_reg == SETTLING) begin
            // This cycle is the SETTLE-th stable sample: capture once,
            // then HOLD so the same dwell is not captured again
            if (cnt_reg == 8'(SETTLE - 1)) begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            cnt_next = cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ref_idx_reg <= '0;
            ref_seg_reg <= '0;
`ifdef SEG7_DP_CAPTURE_EN
            ref_dp_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            ref_idx_reg <= ref_idx_next;
            ref_seg_reg <= ref_seg_next;
`ifdef SEG7_DP_CAPTURE_EN
            ref_dp_reg  <= ref_dp_next;
`endif
        end
    end

    // Per-digit shadow registers
    logic [4*DIGITS-1:0] nib_shadow;
    logic [DIGITS-1:0]   err_shadow;
    logic [DIGITS-1:0]   cap_mask;
`ifdef SEG7_DP_CAPTURE_EN
    logic [DIGITS-1:0]   dp_shadow;
`endif

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nib_reg;
            logic       err_reg;
            assign cap_mask[gi]          = capture && (ref_idx_reg == IDX_W'(gi));
            assign nib_shadow[4*gi +: 4] = nib_reg;
            assign err_shadow[gi]        = err_reg;

            always_ff @(posedge clk) begin
                if (clr) begin
                    nib_reg <= '0;
                    err_reg <= 1'b0;
                end else if (cap_mask[gi]) begin
                    nib_reg <= dec_nib;
                    err_reg <= dec_err;
                end
            end
`ifdef SEG7_DP_CAPTURE_EN
            logic dp_reg;
            assign dp_shadow[gi] = dp_reg;
            always_ff @(posedge clk) begin
                if (clr)               dp_reg <= 1'b0;
                else if (cap_mask[gi]) dp_reg <= ~dp_s2_reg;
            end
`endif
        end
    endgenerate

    // Frame assembly and dead-bus timeout
    logic [DIGITS-1:0]   seen_reg;
    logic [TO_W-1:0]     tcnt_reg;
    logic [4*DIGITS-1:0] value_reg;
    logic [DIGITS-1:0]   err_mask_reg;
    logic                frame_valid_reg, stale_reg;
    logic                frame_done, stale_set;

    assign frame_done = &seen_reg;
    assign stale_set  = !capture && (tcnt_reg == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            seen_reg        <= '0;
            tcnt_reg        <= '0;
            value_reg       <= '0;
            err_mask_reg    <= '0;
            frame_valid_reg <= 1'b0;
            stale_reg       <= 1'b0;
        end else begin
            frame_valid_reg <= frame_done;
            if (frame_done) begin
                value_reg    <= nib_shadow;
                err_mask_reg <= err_shadow;
            end

            // Stale discards the partial frame; a capture in the publish
            // cycle already belongs to the next frame
            if (stale_set)       seen_reg <= '0;
            else if (frame_done) seen_reg <= cap_mask;
            else                 seen_reg <= seen_reg | cap_mask;

            if (capture) begin
                tcnt_reg  <= '0;
                stale_reg <= 1'b0;
            end else if (tcnt_reg != TO_W'(TIMEOUT)) begin
                tcnt_reg <= tcnt_reg + 1'b1;
                if (stale_set) stale_reg <= 1'b1;
            end
        end
    end

`ifdef SEG7_DP_CAPTURE_EN
    logic [DIGITS-1:0] dp_mask_reg;
    always_ff @(posedge clk) begin
        if (clr)             dp_mask_reg <= '0;
        else if (frame_done) dp_mask_reg <= dp_shadow;
    end
    assign dp_mask = dp_mask_reg;
`endif

    assign value       = value_reg;
    assign err_mask    = err_mask_reg;
    assign frame_valid = frame_valid_reg;
    assign stale       = stale_reg;

endmodule

// File: tb/tb_seg7_scan_capture.sv
module tb_seg7_scan_capture;

    localparam int DIGITS  = 4;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  err_mask;
    logic        stale;
`ifdef SEG7_DP_CAPTURE_EN
    logic        dp = 1'b1;
    logic [3:0]  dp_mask;
`endif

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int fv_count = 0;
    int fv_base;

    always #5 clk = ~clk;

    seg7_scan_capture #(
        .DIGITS (DIGITS),
        .SETTLE (SETTLE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .an         (an),
        .a_to_g     (a_to_g),
`ifdef SEG7_DP_CAPTURE_EN
        .dp         (dp),
        .dp_mask    (dp_mask),
`endif
        .value      (value),
        .frame_valid(frame_valid),
        .err_mask   (err_mask),
        .stale      (stale)
    );

    // Count frame_valid high cycles away from the active edge
    always @(negedge clk) if (frame_valid) fv_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        an     = a;
        a_to_g = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Four digits in order 0..3, 20 cycles each, then a short blank
    task automatic frame4(input logic [6:0] s0, input logic [6:0] s1,
                          input logic [6:0] s2, input logic [6:0] s3);
        show(4'b1110, s0, 20);
        show(4'b1101, s1, 20);
        show(4'b1011, s2, 20);
        show(4'b0111, s3, 20);
        show(4'b1111, 7'h7F, 5);
    endtask

    initial begin
        clr = 1'b1; an = 4'hF; a_to_g = 7'h7F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_fv", 32'(frame_valid), 32'h0);
        check("reset_err", 32'(err_mask), 32'h0);
        check("reset_stale", 32'(stale), 32'h0);
        clr = 1'b0;

        // Basic frame 5432
        fv_base = fv_count;
        frame4(7'h12, 7'h06, 7'h4C, 7'h24);
        check("f1_pulses", 32'(fv_count - fv_base), 32'd1);
        check("f1_value", 32'(value), 32'h5432);
        check("f1_err", 32'(err_mask), 32'h0);

        // Glitching digit 0 after digits 1..3 are already seen
        fv_base = fv_count;
        show(4'b1101, 7'h06, 20);
        show(4'b1011, 7'h4C, 20);
        show(4'b0111, 7'h24, 20);
        for (int k = 0; k < 10; k++) show(4'b1110, (k % 2 == 0) ? 7'h4F : 7'h01, 3);
        check("glitch_nocap", 32'(fv_count - fv_base), 32'd0);
        show(4'b1110, 7'h4F, 9);
        check("glitch_early", 32'(fv_count - fv_base), 32'd0);
        show(4'b1110, 7'h4F, 11);
        check("glitch_pulse", 32'(fv_count - fv_base), 32'd1);
        check("glitch_value", 32'(value), 32'h5431);

        // Invalid pattern on digit 2
        fv_base = fv_count;
        frame4(7'h06, 7'h12, 7'h7F, 7'h0F);
        check("inv_pulses", 32'(fv_count - fv_base), 32'd1);
        check("inv_value", 32'(value), 32'h7023);
        check("inv_err", 32'(err_mask), 32'b0100);

        // Blanking and a two-low strobe between digits
        fv_base = fv_count;
        show(4'b1110, 7'h00, 20);
        show(4'b1111, 7'h00, 5);
        show(4'b1100, 7'h20, 20);
        show(4'b1111, 7'h20, 5);
        show(4'b1101, 7'h04, 20);
        show(4'b1111, 7'h04, 5);
        show(4'b1011, 7'h08, 20);
        check("blank_partial", 32'(fv_count - fv_base), 32'd0);
        show(4'b0111, 7'h60, 20);
        show(4'b1111, 7'h7F, 5);
        check("blank_pulses", 32'(fv_count - fv_base), 32'd1);
        check("blank_value", 32'(value), 32'hBA98);
        check("blank_err", 32'(err_mask), 32'h0);

        // Dead bus after a partial frame
        fv_base = fv_count;
        show(4'b1110, 7'h31, 20);
        show(4'b1101, 7'h42, 20);
        show(4'b1111, 7'h7F, TIMEOUT - 30);
        check("to_not_yet", 32'(stale), 32'h0);
        show(4'b1111, 7'h7F, 40);
        check("to_stale", 32'(stale), 32'h1);
        check("to_value", 32'(value), 32'hBA98);
        check("to_pulses", 32'(fv_count - fv_base), 32'd0);
        show(4'b1011, 7'h30, 20);
        check("to_stale_clr", 32'(stale), 32'h0);
        show(4'b0111, 7'h38, 20);
        check("to_discard", 32'(fv_count - fv_base), 32'd0);
        show(4'b1110, 7'h01, 20);
        show(4'b1101, 7'h4F, 20);
        show(4'b1111, 7'h7F, 5);
        check("to_pulses2", 32'(fv_count - fv_base), 32'd1);
        check("to_value2", 32'(value), 32'hFE10);
        check("to_stale2", 32'(stale), 32'h0);

        // Reset in the middle of a dwell with a partial frame
        show(4'b1110, 7'h12, 20);
        show(4'b1101, 7'h06, 20);
        show(4'b1011, 7'h4C, 6);
        clr = 1'b1;
        show(4'b1111, 7'h7F, 2);
        check("clr_value", 32'(value), 32'h0);
        check("clr_err", 32'(err_mask), 32'h0);
        check("clr_stale", 32'(stale), 32'h0);
        check("clr_fv", 32'(frame_valid), 32'h0);
        clr = 1'b0;
        fv_base = fv_count;
        show(4'b1011, 7'h0F, 20);
        show(4'b0111, 7'h00, 20);
        show(4'b1111, 7'h7F, 5);
        check("clr_partial", 32'(fv_count - fv_base), 32'd0);
        show(4'b1110, 7'h24, 20);
        show(4'b1101, 7'h20, 20);
        show(4'b1111, 7'h7F, 5);
        check("clr_pulses", 32'(fv_count - fv_base), 32'd1);
        check("clr_value2", 32'(value), 32'h8765);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a time-multiplexed 7-segment display bus (active-low anode strobes plus active-low segment lines) and decodes each strobed pattern back to a hex nibble.
- Assembles the nibbles into a multi-digit word and flags invalid patterns and a dead bus.
- Used for loopback checking of display drivers and for snooping external display boards.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- SETTLE, 8, consecutive stable cycles required before a digit is sampled (2..255).
- TIMEOUT, 65535, cycles without any capture before stale asserts (≥ SETTLE·2).

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous active-high reset
- an  in  DIGITS  anode strobes, active-low, one-hot-low when a digit is driven
- a_to_g  in  7  segment lines, [6]=a … [0]=g, segment lit when bit=0
- value  out  4*DIGITS  captured word, digit i at value[4i+3:4i]
- frame_valid  out  1  one-cycle pulse when value/err_mask update
- err_mask  out  DIGITS  bit i set = digit i held a non-hex pattern in the last frame
- stale  out  1  no capture for TIMEOUT cycles

Behaviour:
- Reset: clr sampled on rising clk only; takes priority over all other activity.
  - Clears value=0, frame_valid=0, err_mask=0, stale=0, seen mask, counters and sync flops.
  - State goes to IDLE.
- Input path: an and a_to_g pass through a 2-flop synchronizer. All logic below uses the synced copies.
- Decode table (a_to_g hex → nibble):
  - 01→0, 4F→1, 12→2, 06→3, 4C→4, 24→5, 20→6, 0F→7
  - 00→8, 04→9, 08→A, 60→b, 31→C, 42→d, 30→E, 38→F
  - Any other code is invalid: decoded nibble = 0, error bit = 1.
- Strobe valid: exactly one bit of synced an is 0. All-high (blanking) or more than one low is not valid.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: on valid strobe, go to SETTLE; load the counter with 1, latch the strobe index and segment pattern as reference.
  - SETTLE:
    - Strobe and pattern both equal to reference: counter increments.
    - Either differs: reload reference, counter=1, stay in SETTLE.
    - Strobe becomes invalid: go to IDLE.
    - Counter reaches SETTLE: capture (below), go to HOLD.
  - HOLD:
    - Remains while strobe and pattern are unchanged. The same digit is never captured twice per dwell.
    - Any change with a valid strobe: go to SETTLE with the new reference.
    - Invalid strobe: go to IDLE.
- Capture (single cycle):
  - Write nibble into the digit[i] shadow register; write error bit into shadow err[i]; set seen[i].
  - Restart the timeout counter; clear stale.
  - Capture latency is 2 sync cycles + SETTLE cycles after the pattern appears.
- Frame completion:
  - In the cycle after a capture makes seen all-ones: copy shadows to value/err_mask, pulse frame_valid for 1 cycle, clear seen.
  - A capture that lands in the same cycle sets seen for the new frame.
  - Digits may arrive in any order. A repeated digit before frame completion overwrites its shadow.
- Timeout: counter saturates at TIMEOUT and then asserts stale.
  - value and err_mask hold their last values.
  - The seen mask is cleared when stale asserts, so the partial frame is discarded.
- DIGITS=1: every capture completes a frame.

Optional Feature:
- Macro SEG7_DP_CAPTURE_EN.
- When defined, the block adds:
  - Input dp (1 bit, active-low decimal point), synchronized and included in the stability comparison.
  - Output dp_mask (DIGITS bits, bit i = decimal point lit in the last frame), updated with value.
  - dp_mask resets to 0.
- When undefined: no dp port, no dp_mask port, and no dp logic.

Test Plan:
- Reset then drive an=1110 with a_to_g=0x12, an=1101 with 0x06, an=1011 with 0x4C, an=0111 with 0x24, each for 20 cycles → one frame_valid pulse, value=0x5432, err_mask=0000.
- Glitch: digit 0 with 0x4F, toggled to 0x01 every 3 cycles for 30 cycles, then steady 0x4F → no capture during the glitching; digit 0 = 1 after SETTLE stable cycles.
- Invalid pattern 0x7F on digit 2 within a full frame → frame_valid asserts, value[11:8]=0, err_mask=0100.
- Blanking: all-high an for 5 cycles between digits and a two-low strobe an=1100 → neither captured; frame still completes from the valid dwells.
- Bus stopped after digits 0 and 1 for TIMEOUT+10 cycles → stale=1, value unchanged. Next full frame → stale=0, new value, frame_valid pulse.
- Assert clr mid-SETTLE with a partial frame → all outputs 0. A new full frame is required before frame_valid asserts.
